// File: rtl/dm_responder.sv
// Data-memory responder: registered IDLE/WAIT/RESP handshake with byte/half/word lanes and fault detection.
// Define DM_WAIT_EN to compile in the WAIT state and wait counter (latency WAIT_CYCLES+1, otherwise 1).
module dm_responder #(
  parameter int DEPTH_WORDS = 4096,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic        stall
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

`ifdef DM_WAIT_EN
  localparam bit HAS_WAIT = (WAIT_CYCLES > 0);
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;
`else
  localparam bit HAS_WAIT = 1'b0;
  typedef enum logic [1:0] {IDLE = 2'd0, RESP = 2'd2} state_t;
`endif

  state_t state;
  logic [31:0] mem [DEPTH_WORDS];

  logic        x_we;
  logic [31:0] x_addr;
  logic [31:0] x_wdata;
  logic [1:0]  x_size;
  logic        x_sign_ext;

`ifdef DM_WAIT_EN
  logic [CW-1:0] count;
  logic        l_we;
  logic [31:0] l_addr;
  logic [31:0] l_wdata;
  logic [1:0]  l_size;
  logic        l_sign_ext;

  // Execution uses live inputs only when accepting straight out of IDLE.
  always_comb begin
    x_we       = l_we;
    x_addr     = l_addr;
    x_wdata    = l_wdata;
    x_size     = l_size;
    x_sign_ext = l_sign_ext;
    if (state == IDLE) begin
      x_we       = we;
      x_addr     = addr;
      x_wdata    = wdata;
      x_size     = size;
      x_sign_ext = sign_ext;
    end
  end
`else
  assign x_we       = we;
  assign x_addr     = addr;
  assign x_wdata    = wdata;
  assign x_size     = size;
  assign x_sign_ext = sign_ext;
`endif

  logic          exec;
  logic          fault;
  logic [31:0]   word_idx;
  logic [AW-1:0] mem_idx;
  logic [31:0]   cur_word;
  logic [31:0]   shifted;
  logic [31:0]   load_val;
  logic [31:0]   wd_rep;
  logic [3:0]    be;
  logic [31:0]   new_word;

  always_comb begin
    exec = (state == IDLE) && req && !HAS_WAIT;
`ifdef DM_WAIT_EN
    if (state == WAIT && count == '0) exec = 1'b1;
`endif
  end

`ifdef DM_WAIT_EN
  assign stall = ((state == IDLE) && req) || (state == WAIT);
`else
  assign stall = (state == IDLE) && req;
`endif

  assign word_idx = {2'b00, x_addr[31:2]};
  assign mem_idx  = word_idx[AW-1:0];
  assign fault    = (x_size == 2'b11)
                 || (x_size == 2'b01 && x_addr[0])
                 || (x_size == 2'b10 && x_addr[1:0] != 2'b00)
                 || (word_idx >= 32'(DEPTH_WORDS));

  assign cur_word = mem[mem_idx];
  assign shifted  = cur_word >> {x_addr[1:0], 3'b000};

  always_comb begin
    case (x_size)
      2'b00:   load_val = {{24{x_sign_ext & shifted[7]}}, shifted[7:0]};
      2'b01:   load_val = {{16{x_sign_ext & shifted[15]}}, shifted[15:0]};
      default: load_val = cur_word;
    endcase
  end

  // Replicate store data across lanes so the byte enables alone pick the target.
  always_comb begin
    case (x_size)
      2'b00: begin
        wd_rep = {4{x_wdata[7:0]}};
        be     = 4'b0001 << x_addr[1:0];
      end
      2'b01: begin
        wd_rep = {2{x_wdata[15:0]}};
        be     = x_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        wd_rep = x_wdata;
        be     = 4'b1111;
      end
    endcase
    for (int b = 0; b < 4; b++)
      new_word[b*8 +: 8] = be[b] ? wd_rep[b*8 +: 8] : cur_word[b*8 +: 8];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ready <= 1'b0;
      err   <= 1'b0;
      rdata <= '0;
`ifdef DM_WAIT_EN
      count <= '0;
`endif
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          ready <= 1'b0;
`ifdef DM_WAIT_EN
          if (req) begin
            l_we       <= we;
            l_addr     <= addr;
            l_wdata    <= wdata;
            l_size     <= size;
            l_sign_ext <= sign_ext;
            if (HAS_WAIT) begin
              count <= CW'(WAIT_CYCLES - 1);
              state <= WAIT;
            end
          end
`endif
        end
`ifdef DM_WAIT_EN
        WAIT: begin
          if (count != '0) count <= count - 1'b1;
        end
`endif
        RESP: begin
          ready <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (exec) begin
        state <= RESP;
        ready <= 1'b1;
        err   <= fault;
        rdata <= (fault || x_we) ? 32'h0 : load_val;
        if (x_we && !fault) mem[mem_idx] <= new_word;
      end
    end
  end

endmodule

// File: tb/tb_dm_responder.sv
// Self-checking bench for dm_responder; expectations are queued at issue time and popped on each ready pulse.
module tb_dm_responder;

  localparam int WAIT = 2;
`ifdef DM_WAIT_EN
  localparam int LAT = WAIT + 1;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] rdata;
  logic        ready;
  logic        err;
  logic        stall;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] er;
    logic        ee;
    bit          cd;
  } exp_t;

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0]  s;
    logic        sx;
    logic [31:0] er;
    logic        ee;
    bit          cd;
  } acc_t;

  exp_t sb[$];

  dm_responder #(.DEPTH_WORDS(4096), .WAIT_CYCLES(WAIT)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .size(size), .sign_ext(sign_ext), .rdata(rdata), .ready(ready), .err(err), .stall(stall)
  );

  always #5 clk = ~clk;

  // Drives one request, holds it until the response strobe, returns what was seen.
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] s, input logic sx,
                       output logic [31:0] o_rdata, output logic o_err, output int o_lat);
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d; size = s; sign_ext = sx;
    o_lat = -1; o_rdata = 'x; o_err = 'x;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (ready) begin
        o_lat = i; o_rdata = rdata; o_err = err;
        break;
      end
    end
    req = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; size = 2'b10; sign_ext = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", ready); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", rdata); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
    reset = 1'b0;
  endtask

  task automatic test_store_load();
    acc_t tbl[6];
    exp_t e;
    logic [31:0] r; logic ef; int lat;
    tbl = '{
      '{1'b1, 32'h10, 32'h12345678, 2'b10, 1'b0, 32'h0,        1'b0, 1'b0},
      '{1'b0, 32'h10, 32'h0,        2'b10, 1'b0, 32'h12345678, 1'b0, 1'b1},
      '{1'b1, 32'h13, 32'hAB,       2'b00, 1'b0, 32'h0,        1'b0, 1'b0},
      '{1'b0, 32'h13, 32'h0,        2'b00, 1'b1, 32'hFFFFFFAB, 1'b0, 1'b1},
      '{1'b0, 32'h12, 32'h0,        2'b01, 1'b0, 32'h0000AB34, 1'b0, 1'b1},
      '{1'b0, 32'h10, 32'h0,        2'b10, 1'b0, 32'hAB345678, 1'b0, 1'b1}
    };
    foreach (tbl[i]) begin
      sb.push_back('{tbl[i].er, tbl[i].ee, tbl[i].cd});
      issue(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].s, tbl[i].sx, r, ef, lat);
      e = sb.pop_front();
      checks++; if (lat !== LAT) begin errors++; $display("FAIL store_load[%0d] latency got %0d want %0d", i, lat, LAT); end
      checks++; if (ef !== e.ee) begin errors++; $display("FAIL store_load[%0d] err got %b want %b", i, ef, e.ee); end
      if (e.cd) begin
        checks++; if (r !== e.er) begin errors++; $display("FAIL store_load[%0d] rdata got %h want %h", i, r, e.er); end
      end
    end
  endtask

  task automatic test_fault();
    acc_t tbl[9];
    exp_t e;
    logic [31:0] r; logic ef; int lat;
    tbl = '{
      '{1'b0, 32'h02,   32'h0,        2'b10, 1'b0, 32'h0,        1'b1, 1'b1},
      '{1'b1, 32'h11,   32'hFFFF,     2'b01, 1'b0, 32'h0,        1'b1, 1'b1},
      '{1'b1, 32'h12,   32'hFFFFFFFF, 2'b11, 1'b0, 32'h0,        1'b1, 1'b1},
      '{1'b1, 32'h4000, 32'h55,       2'b10, 1'b0, 32'h0,        1'b1, 1'b1},
      '{1'b0, 32'h4000, 32'h0,        2'b10, 1'b0, 32'h0,        1'b1, 1'b1},
      '{1'b0, 32'h10,   32'h0,        2'b10, 1'b0, 32'hAB345678, 1'b0, 1'b1},
      '{1'b0, 32'h00,   32'h0,        2'b10, 1'b0, 32'h0,        1'b0, 1'b1},
      '{1'b1, 32'h3FFC, 32'hCAFEF00D, 2'b10, 1'b0, 32'h0,        1'b0, 1'b0},
      '{1'b0, 32'h3FFC, 32'h0,        2'b10, 1'b0, 32'hCAFEF00D, 1'b0, 1'b1}
    };
    foreach (tbl[i]) begin
      sb.push_back('{tbl[i].er, tbl[i].ee, tbl[i].cd});
      issue(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].s, tbl[i].sx, r, ef, lat);
      e = sb.pop_front();
      checks++; if (ef !== e.ee) begin errors++; $display("FAIL fault[%0d] err got %b want %b", i, ef, e.ee); end
      if (e.cd) begin
        checks++; if (r !== e.er) begin errors++; $display("FAIL fault[%0d] rdata got %h want %h", i, r, e.er); end
      end
    end
  endtask

  task automatic test_lanes();
    acc_t tbl[8];
    exp_t e;
    logic [31:0] r; logic ef; int lat;
    tbl = '{
      '{1'b1, 32'h16, 32'h8001, 2'b01, 1'b0, 32'h0,        1'b0, 1'b0},
      '{1'b0, 32'h16, 32'h0,    2'b01, 1'b1, 32'hFFFF8001, 1'b0, 1'b1},
      '{1'b0, 32'h17, 32'h0,    2'b00, 1'b0, 32'h00000080, 1'b0, 1'b1},
      '{1'b0, 32'h16, 32'h0,    2'b00, 1'b1, 32'h00000001, 1'b0, 1'b1},
      '{1'b0, 32'h14, 32'h0,    2'b10, 1'b0, 32'h80010000, 1'b0, 1'b1},
      '{1'b1, 32'h15, 32'h1FF,  2'b00, 1'b0, 32'h0,        1'b0, 1'b0},
      '{1'b0, 32'h14, 32'h0,    2'b10, 1'b0, 32'h8001FF00, 1'b0, 1'b1},
      '{1'b0, 32'h15, 32'h0,    2'b00, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b1}
    };
    foreach (tbl[i]) begin
      sb.push_back('{tbl[i].er, tbl[i].ee, tbl[i].cd});
      issue(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].s, tbl[i].sx, r, ef, lat);
      e = sb.pop_front();
      checks++; if (ef !== e.ee) begin errors++; $display("FAIL lanes[%0d] err got %b want %b", i, ef, e.ee); end
      if (e.cd) begin
        checks++; if (r !== e.er) begin errors++; $display("FAIL lanes[%0d] rdata got %h want %h", i, r, e.er); end
      end
    end
  endtask

  task automatic test_back_to_back();
    localparam int P = LAT + 1;
    exp_t e;
    int phase;
    sb.push_back('{32'hAB345678, 1'b0, 1'b1});
    sb.push_back('{32'hAB345678, 1'b0, 1'b1});
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h10; wdata = '0; size = 2'b10; sign_ext = 1'b0;
    for (int c = 0; c < 2 * P; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      phase = c % P;
      checks++; if (stall !== (phase != LAT)) begin errors++; $display("FAIL b2b stall cycle %0d got %b want %b", c, stall, phase != LAT); end
      checks++; if (ready !== (phase == LAT)) begin errors++; $display("FAIL b2b ready cycle %0d got %b want %b", c, ready, phase == LAT); end
      if (ready && sb.size() > 0) begin
        e = sb.pop_front();
        checks++; if (rdata !== e.er) begin errors++; $display("FAIL b2b rdata cycle %0d got %h want %h", c, rdata, e.er); end
      end
    end
    req = 1'b0;
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL b2b responses missing got %0d left want 0", sb.size()); sb.delete(); end
    repeat (2) @(negedge clk);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL hold_ready got %b want 0", ready); end
    checks++; if (rdata !== 32'hAB345678) begin errors++; $display("FAIL hold_rdata got %h want ab345678", rdata); end
  endtask

  task automatic test_reset_abort();
    exp_t e;
    logic [31:0] r; logic ef; int lat;
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'hDEADBEEF; size = 2'b10; sign_ext = 1'b0;
`ifdef DM_WAIT_EN
    @(negedge clk);
`endif
    reset = 1'b1; req = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL abort_ready_in_reset cycle %0d got %b want 0", c, ready); end
    end
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL abort_ready_after cycle %0d got %b want 0", c, ready); end
    end
    sb.push_back('{32'h0, 1'b0, 1'b1});
    issue(1'b0, 32'h20, 32'h0, 2'b10, 1'b0, r, ef, lat);
    e = sb.pop_front();
    checks++; if (r !== e.er) begin errors++; $display("FAIL abort_load rdata got %h want %h", r, e.er); end
    checks++; if (ef !== e.ee) begin errors++; $display("FAIL abort_load err got %b want %b", ef, e.ee); end
    sb.push_back('{32'h0, 1'b0, 1'b1});
    issue(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, r, ef, lat);
    e = sb.pop_front();
    checks++; if (r !== e.er) begin errors++; $display("FAIL cleared_load rdata got %h want %h", r, e.er); end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_fault();
    test_lanes();
    test_back_to_back();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
